// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the 8-bit RISC instruction-cycle controller:
//   - opcode values of the 3-bit IR opcode field
//   - debug state encoding (S0..S7 = 0..7, IDLE = 8, HALT = 9)
//   - the set of opcodes that write the accumulator
//   - the packed strobe vector driven by the decoder
// -----------------------------------------------------------------------------
package cpu_defs;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [3:0] ST_S0   = 4'd0;
   localparam logic [3:0] ST_S1   = 4'd1;
   localparam logic [3:0] ST_S2   = 4'd2;
   localparam logic [3:0] ST_S3   = 4'd3;
   localparam logic [3:0] ST_S4   = 4'd4;
   localparam logic [3:0] ST_S5   = 4'd5;
   localparam logic [3:0] ST_S6   = 4'd6;
   localparam logic [3:0] ST_S7   = 4'd7;
   localparam logic [3:0] ST_IDLE = 4'd8;
   localparam logic [3:0] ST_HALT = 4'd9;

   // One bit per opcode value: ADD, AND, XOR and LDA load the accumulator.
   localparam logic [7:0] ACC_OP_SET = 8'b0011_1100;

   typedef struct packed {
      logic fetch;
      logic alu_ena;
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic load_ir;
      logic rd;
      logic wr;
      logic datactl_ena;
      logic halt;
   } strobes_t;

   function automatic logic is_acc_op(input logic [2:0] op);
      return ACC_OP_SET[op];
   endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_decode
// Purely combinational map from controller state to the strobe vector.
// Ports:
//   state_i  [3:0]  current controller state
//   op_i     [2:0]  opcode latched in S2
//   zero_i          live accumulator-zero flag (used for SKZ in S5)
//   z_i             zero flag latched in S5 (used for SKZ in S7)
//   strb_o          strobe vector (fetch, alu_ena, inc_pc, ... halt)
// -----------------------------------------------------------------------------
module cpu_ctrl_decode
   import cpu_defs::*;
(
   input  logic [3:0] state_i,
   input  logic [2:0] op_i,
   input  logic       zero_i,
   input  logic       z_i,
   output strobes_t   strb_o
);

   // Strobe decode; every strobe defaults low and is raised per state/opcode.
   always_comb begin
      strb_o = '0;
      case (state_i)
         ST_S0: begin
            strb_o.fetch   = 1'b1;
            strb_o.rd      = 1'b1;
            strb_o.load_ir = 1'b1;
         end
         ST_S1: begin
            strb_o.fetch   = 1'b1;
            strb_o.rd      = 1'b1;
            strb_o.load_ir = 1'b1;
            strb_o.inc_pc  = 1'b1;
         end
         ST_S2: begin
            strb_o.fetch = 1'b1;
         end
         ST_S3: begin
            strb_o.fetch  = 1'b1;
            strb_o.halt   = (op_i == OP_HLT);
            strb_o.inc_pc = (op_i != OP_HLT);
         end
         ST_S4: begin
            strb_o.alu_ena = 1'b1;
            case (op_i)
               OP_JMP:  strb_o.load_pc     = 1'b1;
               OP_STO:  strb_o.datactl_ena = 1'b1;
               default: strb_o.rd          = is_acc_op(op_i);
            endcase
         end
         ST_S5: begin
            case (op_i)
               OP_JMP: strb_o.load_pc = 1'b1;
               OP_STO: begin
                  strb_o.wr          = 1'b1;
                  strb_o.datactl_ena = 1'b1;
               end
               // SKZ looks at the live flag here; S7 uses the copy latched now.
               OP_SKZ: strb_o.inc_pc = zero_i;
               default: begin
                  strb_o.rd       = is_acc_op(op_i);
                  strb_o.load_acc = is_acc_op(op_i);
               end
            endcase
         end
         ST_S6: begin
            case (op_i)
               OP_STO:  strb_o.datactl_ena = 1'b1;
               default: strb_o.rd          = is_acc_op(op_i);
            endcase
         end
         ST_S7: begin
            strb_o.inc_pc = (op_i == OP_SKZ) && z_i;
         end
         ST_HALT: begin
            strb_o.halt = 1'b1;
         end
         default: begin
            strb_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm_chk.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm_chk
// Property checker for the controller strobes: memory read/write never
// overlap, PC load and increment never overlap, a write always has the
// accumulator driving the bus, and nothing is written while in reset.
// Ports: clk, rst_n and the strobes rd, wr, load_pc, inc_pc, datactl_ena.
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm_chk (
   input logic clk,
   input logic rst_n,
   input logic rd,
   input logic wr,
   input logic load_pc,
   input logic inc_pc,
   input logic datactl_ena
);

   a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rd && wr));
   a_pc_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(load_pc && inc_pc));
   a_wr_drive:   assert property (@(posedge clk) disable iff (!rst_n) (wr -> datactl_ena));
   a_no_wr_rst:  assert property (@(posedge clk) !rst_n |-> !wr);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
// Instruction-cycle controller: fetch two bytes (S0..S1), decode (S2..S3),
// execute (S4..S7), with IDLE and HALT. Strobes are combinational from the
// state register and the latched opcode/zero flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             run enable (level)
//   opcode [2:0]    IR opcode field, sampled in S2 only
//   zero            accumulator-zero flag, sampled in S5
//   fetch .. halt   control strobes
//   state  [3:0]    current state for debug
// Parameter HALT_RESTART: 1 = HALT leaves to IDLE when ena is low,
//                         0 = HALT is only left through reset.
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm
   import cpu_defs::*;
#(
   parameter bit HALT_RESTART = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       fetch,
   output logic       alu_ena,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       load_ir,
   output logic       rd,
   output logic       wr,
   output logic       datactl_ena,
   output logic       halt,
   output logic [3:0] state
);

   logic [3:0] state_q, state_d;
   logic [2:0] op_q, op_d;
   logic       z_q, z_d;
   strobes_t   strb_s;

   // Next-state and latch-enable logic.
   always_comb begin
      state_d = state_q;
      op_d    = (state_q == ST_S2) ? opcode : op_q;
      z_d     = (state_q == ST_S5) ? zero   : z_q;
      case (state_q)
         ST_IDLE: begin
            if (ena) state_d = ST_S0;
            else     state_d = ST_IDLE;
         end
         ST_S0, ST_S1, ST_S2, ST_S4, ST_S5, ST_S6: begin
            state_d = state_q + 4'd1;
         end
         ST_S3: begin
            if (op_q == OP_HLT) state_d = ST_HALT;
            else                state_d = ST_S4;
         end
         // ena is only looked at between instructions, so a drop completes it.
         ST_S7: begin
            if (ena) state_d = ST_S0;
            else     state_d = ST_IDLE;
         end
         ST_HALT: begin
            if (HALT_RESTART && !ena) state_d = ST_IDLE;
            else                      state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, opcode and zero-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= 3'd0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         z_q     <= z_d;
      end
   end

   cpu_ctrl_decode u_decode (
      .state_i (state_q),
      .op_i    (op_q),
      .zero_i  (zero),
      .z_i     (z_q),
      .strb_o  (strb_s)
   );

   assign fetch       = strb_s.fetch;
   assign alu_ena     = strb_s.alu_ena;
   assign inc_pc      = strb_s.inc_pc;
   assign load_pc     = strb_s.load_pc;
   assign load_acc    = strb_s.load_acc;
   assign load_ir     = strb_s.load_ir;
   assign rd          = strb_s.rd;
   assign wr          = strb_s.wr;
   assign datactl_ena = strb_s.datactl_ena;
   assign halt        = strb_s.halt;
   assign state       = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;

   localparam int OPC_HLT = 0, OPC_SKZ = 1, OPC_ADD = 2, OPC_AND = 3;
   localparam int OPC_XOR = 4, OPC_LDA = 5, OPC_STO = 6, OPC_JMP = 7;
   localparam int M_RUN = 0, M_IDLE = 1, M_HALT = 2;

   logic       clk = 1'b0;
   logic       rst_n, ena, zero;
   logic [2:0] opcode;

   logic fetch_r, alu_ena_r, inc_pc_r, load_pc_r, load_acc_r, load_ir_r, rd_r, wr_r, dc_r, halt_r;
   logic fetch_h, alu_ena_h, inc_pc_h, load_pc_h, load_acc_h, load_ir_h, rd_h, wr_h, dc_h, halt_h;
   logic [3:0] state_r, state_h;
   logic [9:0] strb_r, strb_h;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cpu_ctrl_fsm #(.HALT_RESTART(1'b1)) dut_r (
      .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
      .fetch(fetch_r), .alu_ena(alu_ena_r), .inc_pc(inc_pc_r), .load_pc(load_pc_r),
      .load_acc(load_acc_r), .load_ir(load_ir_r), .rd(rd_r), .wr(wr_r),
      .datactl_ena(dc_r), .halt(halt_r), .state(state_r));

   cpu_ctrl_fsm #(.HALT_RESTART(1'b0)) dut_h (
      .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
      .fetch(fetch_h), .alu_ena(alu_ena_h), .inc_pc(inc_pc_h), .load_pc(load_pc_h),
      .load_acc(load_acc_h), .load_ir(load_ir_h), .rd(rd_h), .wr(wr_h),
      .datactl_ena(dc_h), .halt(halt_h), .state(state_h));

   cpu_ctrl_fsm_chk chk_r (.clk(clk), .rst_n(rst_n), .rd(rd_r), .wr(wr_r),
      .load_pc(load_pc_r), .inc_pc(inc_pc_r), .datactl_ena(dc_r));
   cpu_ctrl_fsm_chk chk_h (.clk(clk), .rst_n(rst_n), .rd(rd_h), .wr(wr_h),
      .load_pc(load_pc_h), .inc_pc(inc_pc_h), .datactl_ena(dc_h));

   assign strb_r = {fetch_r, alu_ena_r, inc_pc_r, load_pc_r, load_acc_r, load_ir_r, rd_r, wr_r, dc_r, halt_r};
   assign strb_h = {fetch_h, alu_ena_h, inc_pc_h, load_pc_h, load_acc_h, load_ir_h, rd_h, wr_h, dc_h, halt_h};

   // Reference model: index 0 restarts from HALT, index 1 only leaves HALT on reset.
   int   m_mode [2];
   int   m_step [2];
   int   m_op   [2];
   logic m_z    [2];

   function automatic logic [13:0] expect_out(input int mode, input int step, input int op,
                                              input logic zero_now, input logic zl);
      logic run, acc, f, alu, inc, lpc, lacc, lir, r, w, dc, h;
      int   st;
      run  = (mode == M_RUN);
      acc  = (op == OPC_ADD) || (op == OPC_AND) || (op == OPC_XOR) || (op == OPC_LDA);
      f    = run && step <= 3;
      lir  = run && step <= 1;
      r    = run && (step <= 1 || (acc && step >= 4 && step <= 6));
      alu  = run && step == 4;
      lacc = run && acc && step == 5;
      lpc  = run && op == OPC_JMP && (step == 4 || step == 5);
      w    = run && op == OPC_STO && step == 5;
      dc   = run && op == OPC_STO && step >= 4 && step <= 6;
      inc  = run && (step == 1 || (step == 3 && op != OPC_HLT) ||
                     (op == OPC_SKZ && step == 5 && zero_now) ||
                     (op == OPC_SKZ && step == 7 && zl));
      h    = (mode == M_HALT) || (run && step == 3 && op == OPC_HLT);
      st   = run ? step : ((mode == M_HALT) ? 9 : 8);
      return {st[3:0], f, alu, inc, lpc, lacc, lir, r, w, dc, h};
   endfunction

   // Model state advance.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_mode[k] <= M_IDLE;
            m_step[k] <= 0;
            m_op[k]   <= 0;
            m_z[k]    <= 1'b0;
         end else begin
            case (m_mode[k])
               M_IDLE: if (ena) begin m_mode[k] <= M_RUN; m_step[k] <= 0; end
               M_HALT: if (k == 0 && !ena) m_mode[k] <= M_IDLE;
               default: begin
                  if (m_step[k] == 2) m_op[k] <= int'(opcode);
                  if (m_step[k] == 5) m_z[k] <= zero;
                  if (m_step[k] == 3 && m_op[k] == OPC_HLT) m_mode[k] <= M_HALT;
                  else if (m_step[k] == 7) begin
                     if (ena) m_step[k] <= 0;
                     else     m_mode[k] <= M_IDLE;
                  end else m_step[k] <= m_step[k] + 1;
               end
            endcase
         end
      end
   end

   // Every-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      logic [13:0] e, a;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) e = {4'd8, 10'd0};
         else        e = expect_out(m_mode[k], m_step[k], m_op[k], zero, m_z[k]);
         a = (k == 0) ? {state_r, strb_r} : {state_h, strb_h};
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL model_cmp dut%0d t=%0t got state=%0d strb=%b want state=%0d strb=%b",
                     k, $time, a[13:10], a[9:0], e[13:10], e[9:0]);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   // Runs one instruction from S0, recording per-step strobes of the restart DUT.
   task automatic run_instr(input int op, input bit force_s4, input logic z5, input logic z7,
                            input int drop_at,
                            output logic [7:0] v_rd, output logic [7:0] v_inc,
                            output logic [7:0] v_acc, output logic [7:0] v_alu,
                            output logic [7:0] v_wr, output logic [7:0] v_dc,
                            output logic [7:0] v_lpc, output logic [7:0] v_halt);
      for (int i = 0; i < 8; i++) begin
         opcode = (force_s4 && i == 4) ? 3'd2 : 3'(op);
         zero   = (i == 5) ? z5 : ((i == 7) ? z7 : 1'($urandom_range(0, 1)));
         if (i >= drop_at) ena = 1'b0;
         @(negedge clk);
         v_rd[i] = rd_r;       v_inc[i] = inc_pc_r;  v_acc[i] = load_acc_r; v_alu[i] = alu_ena_r;
         v_wr[i] = wr_r;       v_dc[i]  = dc_r;      v_lpc[i] = load_pc_r;  v_halt[i] = halt_r;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [7:0] v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt;
      rst_n = 1'b0; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("rst_state", int'(state_r), 8);
      chk("rst_strobes", int'(strb_r), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("idle_state", int'(state_r), 8);
      chk("idle_strobes", int'(strb_r), 0);
      @(posedge clk); #1; ena = 1'b1;
      @(posedge clk); #1;
      chk("first_s0_state", int'(state_r), 0);
      chk("first_s0_rd", int'(rd_r), 1);
      chk("first_s0_load_ir", int'(load_ir_r), 1);

      run_instr(OPC_ADD, 1'b0, 1'b0, 1'b0, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("add_rd", int'(v_rd), 8'h73);
      chk("add_inc_pc", int'(v_inc), 8'h0A);
      chk("add_load_acc", int'(v_acc), 8'h20);
      chk("add_alu_ena", int'(v_alu), 8'h10);
      chk("add_wrap_s0", int'(state_r), 0);

      run_instr(OPC_STO, 1'b1, 1'b0, 1'b0, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("sto_datactl", int'(v_dc), 8'h70);
      chk("sto_wr", int'(v_wr), 8'h20);
      chk("sto_rd", int'(v_rd), 8'h03);

      run_instr(OPC_SKZ, 1'b0, 1'b1, 1'b0, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("skz_taken_inc", int'(v_inc), 8'hAA);
      run_instr(OPC_SKZ, 1'b0, 1'b0, 1'b1, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("skz_not_taken_inc", int'(v_inc), 8'h0A);

      run_instr(OPC_JMP, 1'b0, 1'b0, 1'b0, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("jmp_load_pc", int'(v_lpc), 8'h30);
      chk("jmp_inc_pc", int'(v_inc), 8'h0A);

      run_instr(OPC_ADD, 1'b0, 1'b0, 1'b0, 3, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("ena_drop_completes", int'(v_rd), 8'h73);
      chk("ena_drop_idle", int'(state_r), 8);
      ena = 1'b1;
      @(posedge clk); #1;
      chk("restart_s0", int'(state_r), 0);

      run_instr(OPC_HLT, 1'b0, 1'b0, 1'b0, 8, v_rd, v_inc, v_acc, v_alu, v_wr, v_dc, v_lpc, v_halt);
      chk("hlt_halt", int'(v_halt), 8'hF8);
      chk("hlt_inc_pc", int'(v_inc), 8'h02);
      chk("hlt_state_r", int'(state_r), 9);
      chk("hlt_state_h", int'(state_h), 9);
      ena = 1'b0;
      @(posedge clk); #1;
      chk("halt_exit_idle", int'(state_r), 8);
      chk("halt_sticky", int'(state_h), 9);
      ena = 1'b1;
      @(posedge clk); #1;
      chk("halt_rerun_s0", int'(state_r), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_hold_20", int'(state_h), 9);
      end

      // Reset in S5 of a store.
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1; ena = 1'b1; opcode = 3'd6;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
      #1;
      chk("sto_s5_wr", int'(wr_r), 1);
      chk("sto_s5_datactl", int'(dc_r), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr", int'(wr_r), 0);
      chk("rst_mid_datactl", int'(dc_r), 0);
      chk("rst_mid_state", int'(state_r), 8);
      @(posedge clk); #1; rst_n = 1'b1;

      // Randomized run, checked every cycle by the model comparison.
      for (int c = 0; c < 4000; c++) begin
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         ena    = ($urandom_range(0, 15) != 0);
         rst_n  = ($urandom_range(0, 299) != 0);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
